// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding MIPSALU: ALU control decode, EX/MEM and
// MEM/WB operand forwarding, and the immediate select for operand B.
module id_ex_alu_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          id_reg_dst,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [3:0]    alu_ctl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] store_data,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic [RW-1:0] ex_dest,
    output logic          ex_illegal
);

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          illegal;
        logic [CW-1:0] ctl;
        logic          alu_src;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
    } idex_t;

    idex_t         q;
    idex_t         d_load;
    logic [CW-1:0] ctl_dec;
    logic          illegal_dec;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // ALU control from ALUOp/funct; unsupported R-type funct falls back to add
    always_comb begin
        ctl_dec     = 4'b0010;
        illegal_dec = 1'b0;
        case (id_alu_op)
            2'b00: ctl_dec = 4'b0010;
            2'b01: ctl_dec = 4'b0110;
            2'b11: ctl_dec = 4'b0001;
            default: begin
                case (id_funct)
                    6'b100000: ctl_dec = 4'b0010;
                    6'b100010: ctl_dec = 4'b0110;
                    6'b100100: ctl_dec = 4'b0000;
                    6'b100101: ctl_dec = 4'b0001;
                    6'b101010: ctl_dec = 4'b0111;
                    6'b100111: ctl_dec = 4'b1100;
                    default: begin
                        ctl_dec     = 4'b0010;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Next register contents; an invalid decode slot becomes an all-zero bubble
    always_comb begin
        d_load = '0;
        if (id_valid) begin
            d_load.valid     = 1'b1;
            d_load.reg_write = id_reg_write & ~illegal_dec;
            d_load.illegal   = illegal_dec;
            d_load.ctl       = ctl_dec;
            d_load.alu_src   = id_alu_src;
            d_load.rs        = id_rs;
            d_load.rt        = id_rt;
            d_load.dest      = id_reg_dst ? id_rd : id_rt;
            d_load.rs_data   = id_rs_data;
            d_load.rt_data   = id_rt_data;
            d_load.imm       = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d_load;
        end
    end

    // Forwarding stays live while stalled; the nearer stage (EX/MEM) wins
    always_comb begin
        fwd_a = q.rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == q.rs)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == q.rs)) begin
            fwd_a = memwb_result;
        end
    end

    always_comb begin
        fwd_b = q.rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == q.rt)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == q.rt)) begin
            fwd_b = memwb_result;
        end
    end

    assign alu_ctl      = q.ctl;
    assign alu_a        = fwd_a;
    assign alu_b        = q.alu_src ? q.imm : fwd_b;
    assign store_data   = fwd_b;
    assign ex_valid     = q.valid;
    assign ex_reg_write = q.reg_write;
    assign ex_dest      = q.dest;
    assign ex_illegal   = q.illegal;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed scoreboard bench for id_ex_alu_stage: stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor checks them.
module tb_id_ex_alu_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_write, id_reg_dst;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, store_data;
    logic        ex_valid, ex_reg_write, ex_illegal;
    logic [4:0]  ex_dest;

    id_ex_alu_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  ctl;
        logic [31:0] a, b, sd;
        logic        v, rw, ill;
        logic [4:0]  dest;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the expectation due this cycle against the DUT outputs
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                         e.name, e.cyc, cyc);
            end else if ({alu_ctl, alu_a, alu_b, store_data, ex_valid, ex_reg_write, ex_dest, ex_illegal}
                         !== {e.ctl, e.a, e.b, e.sd, e.v, e.rw, e.dest, e.ill}) begin
                errors++;
                $display("FAIL %s: got ctl=%h a=%h b=%h sd=%h v=%b rw=%b dest=%0d ill=%b, expected ctl=%h a=%h b=%h sd=%h v=%b rw=%b dest=%0d ill=%b",
                         e.name, alu_ctl, alu_a, alu_b, store_data, ex_valid, ex_reg_write, ex_dest, ex_illegal,
                         e.ctl, e.a, e.b, e.sd, e.v, e.rw, e.dest, e.ill);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic src, input logic rw, input logic dst,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
        id_valid = v; id_alu_op = op; id_funct = fn; id_alu_src = src;
        id_reg_write = rw; id_reg_dst = dst; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                       input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_reg_write = erw; exmem_rd = erd; exmem_result = eres;
        memwb_reg_write = mrw; memwb_rd = mrd; memwb_result = mres;
    endtask

    // Expectation applies after the next rising edge
    task automatic expect_out(input string nm, input logic [3:0] ctl, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] sd, input logic v,
                              input logic rw, input logic [4:0] dest, input logic ill);
        exp_t e;
        e.cyc = cyc + 1; e.name = nm; e.ctl = ctl; e.a = a; e.b = b; e.sd = sd;
        e.v = v; e.rw = rw; e.dest = dest; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic sub_x();
        instr(1, 2'b10, 6'b100010, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        instr(0, 2'b00, 6'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        step();
        sub_x();
        expect_out("reset", 4'h0, 0, 0, 0, 0, 0, 5'd0, 0);
        step();
        reset = 0;

        sub_x();
        expect_out("sub", 4'h6, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        instr(1, 2'b10, 6'b100100, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("and", 4'h0, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        instr(1, 2'b10, 6'b100101, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("or", 4'h1, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        instr(1, 2'b10, 6'b101010, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("slt", 4'h7, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        instr(1, 2'b10, 6'b100111, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("nor", 4'hC, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        instr(1, 2'b10, 6'b100000, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("add", 4'h2, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        instr(1, 2'b00, 6'b000000, 1, 1, 0, 5'd4, 5'd6, 5'd9, 32'd100, 32'd55, 32'hFFFF_FFFC);
        expect_out("lw", 4'h2, 32'd100, 32'hFFFF_FFFC, 32'd55, 1, 1, 5'd6, 0);
        step();
        instr(1, 2'b01, 6'b000000, 0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd5, 32'd0);
        expect_out("beq", 4'h6, 32'd5, 32'd5, 32'd5, 1, 0, 5'd2, 0);
        step();
        instr(1, 2'b11, 6'b111111, 1, 1, 0, 5'd1, 5'd7, 5'd3, 32'h0F, 32'd3, 32'hF0);
        expect_out("ori", 4'h1, 32'h0F, 32'hF0, 32'd3, 1, 1, 5'd7, 0);
        step();

        instr(1, 2'b10, 6'b100000, 0, 1, 1, 5'd5, 5'd5, 5'd8, 32'd1, 32'd2, 32'd0);
        fwd(1, 5'd5, 32'd7, 1, 5'd5, 32'd9);
        expect_out("fwd_exmem_wins", 4'h2, 32'd7, 32'd7, 32'd7, 1, 1, 5'd8, 0);
        step();
        fwd(0, 5'd5, 32'd7, 1, 5'd5, 32'd9);
        expect_out("fwd_memwb", 4'h2, 32'd9, 32'd9, 32'd9, 1, 1, 5'd8, 0);
        step();
        instr(1, 2'b10, 6'b100000, 0, 1, 1, 5'd0, 5'd0, 5'd8, 32'd1, 32'd2, 32'd0);
        fwd(1, 5'd0, 32'd7, 1, 5'd0, 32'd9);
        expect_out("fwd_r0_never", 4'h2, 32'd1, 32'd2, 32'd2, 1, 1, 5'd8, 0);
        step();
        instr(1, 2'b10, 6'b100000, 0, 1, 1, 5'd5, 5'd6, 5'd8, 32'd1, 32'd2, 32'd0);
        fwd(1, 5'd5, 32'd7, 1, 5'd6, 32'd9);
        expect_out("fwd_split", 4'h2, 32'd7, 32'd9, 32'd9, 1, 1, 5'd8, 0);
        step();
        instr(1, 2'b00, 6'b000000, 1, 0, 0, 5'd5, 5'd6, 5'd8, 32'd1, 32'd2, 32'd8);
        expect_out("sw_fwd", 4'h2, 32'd7, 32'd8, 32'd9, 1, 0, 5'd6, 0);
        step();

        fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        sub_x();
        expect_out("pre_stall", 4'h6, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        stall = 1;
        instr(1, 2'b10, 6'b100100, 0, 0, 0, 5'd9, 5'd10, 5'd11, 32'd99, 32'd98, 32'd5);
        expect_out("stall1", 4'h6, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        fwd(1, 5'd1, 32'h77, 0, 5'd0, 32'd0);
        expect_out("stall2_live_fwd", 4'h6, 32'h77, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        fwd(1, 5'd2, 32'h55, 0, 5'd0, 32'd0);
        expect_out("stall3_live_fwd", 4'h6, 32'd12, 32'h55, 32'h55, 1, 1, 5'd3, 0);
        step();
        flush = 1;
        fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        expect_out("flush_over_stall", 4'h0, 0, 0, 0, 0, 0, 5'd0, 0);
        step();
        stall = 0; flush = 0;
        sub_x();
        expect_out("reload", 4'h6, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        flush = 1;
        expect_out("flush", 4'h0, 0, 0, 0, 0, 0, 5'd0, 0);
        step();
        flush = 0;
        instr(1, 2'b10, 6'b000000, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("illegal", 4'h2, 32'd12, 32'd10, 32'd10, 1, 0, 5'd3, 1);
        step();
        instr(0, 2'b10, 6'b100000, 0, 1, 1, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("invalid_bubble", 4'h0, 0, 0, 0, 0, 0, 5'd0, 0);
        step();
        sub_x();
        expect_out("pre_reset", 4'h6, 32'd12, 32'd10, 32'd10, 1, 1, 5'd3, 0);
        step();
        reset = 1;
        expect_out("mid_reset", 4'h0, 0, 0, 0, 0, 0, 5'd0, 0);
        step();
        reset = 0;
        instr(1, 2'b10, 6'b100101, 0, 1, 0, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd0);
        expect_out("post_reset", 4'h1, 32'd12, 32'd10, 32'd10, 1, 1, 5'd2, 0);
        step();
        instr(0, 2'b00, 6'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS core. It sits directly upstream of MIPSALU and drives its ALUctl, A and B inputs. It captures decoded operands each cycle and generates the 4-bit ALU control code from ALUOp/funct. It resolves EX/MEM and MEM/WB forwarding and the immediate mux, so the ALU sees final operands.

Parameters:
DW, 32, datapath width (operands, results, immediate)
RW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold ID/EX register contents
flush  in  1  replace next ID/EX contents with a bubble
id_valid  in  1  decode stage presents a valid instruction
id_alu_op  in  2  ALUOp from main control
id_funct  in  6  instruction funct field
id_alu_src  in  1  1 = B operand from immediate
id_reg_write  in  1  instruction writes the register file
id_reg_dst  in  1  1 = dest is rd, 0 = dest is rt
id_rs, id_rt, id_rd  in  RW each  register indices
id_rs_data, id_rt_data  in  DW each  register file read data
id_imm  in  DW  sign-extended immediate
exmem_reg_write  in  1  EX/MEM stage writes
exmem_rd  in  RW  EX/MEM destination
exmem_result  in  DW  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB stage writes
memwb_rd  in  RW  MEM/WB destination
memwb_result  in  DW  MEM/WB write-back value
alu_ctl  out  4  to MIPSALU ALUctl
alu_a, alu_b  out  DW each  to MIPSALU A, B
store_data  out  DW  forwarded rt value (for sw)
ex_valid  out  1  EX holds a real instruction
ex_reg_write  out  1  gated reg_write (0 for bubbles)
ex_dest  out  RW  selected destination register
ex_illegal  out  1  R-type funct not supported

Behaviour:
- Reset (reset=1 at clk edge): every register is 0. Outputs then read alu_ctl=0000, ex_valid=0, ex_reg_write=0, ex_dest=0, ex_illegal=0. alu_a/alu_b/store_data are 0 unless forwarding matches rs/rt=0, which it never does.
- Register update priority per edge: reset > flush > stall > load.
- flush=1: load bubble (valid, reg_write, illegal, ctl=0; indices=0), even when stall=1.
- stall=1 (no flush): all registers hold.
- Load: one-cycle latency. Fields are captured from the id_* inputs. When id_valid=0, a bubble is loaded. ex_reg_write = id_reg_write & id_valid. ex_dest = id_reg_dst ? id_rd : id_rt.
- ALU control decode, registered with the instruction:
  - ALUOp 00 -> 0010 (add, lw/sw)
  - ALUOp 01 -> 0110 (sub, beq)
  - ALUOp 11 -> 0001 (or, ori)
  - ALUOp 10 -> by funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111; 100111 -> 1100.
  - Any other funct -> 0010 with ex_illegal=1 and ex_reg_write forced 0.
- Forwarding (combinational from registered state and current exmem/memwb inputs):
  - fwdA: rs_q==exmem_rd && exmem_reg_write && exmem_rd!=0 -> exmem_result. Else the same test against memwb -> memwb_result. Else rs_data_q.
  - fwdB: same rule on rt_q.
  - EX/MEM always wins over MEM/WB when both match. Register 0 is never forwarded.
- alu_a = fwdA. store_data = fwdB. alu_b = alu_src_q ? imm_q : fwdB.
- During stall, forwarding stays live: alu_a/alu_b follow changing exmem/memwb inputs.
- A bubble is a register-level NOP, but outputs still reflect registered zeros.

Test Plan:
- Reset for 2 cycles -> alu_ctl=0000, ex_valid=0, ex_reg_write=0, alu_a=alu_b=0.
- R-type sub (ALUOp=10, funct=100010), rs_data=12, rt_data=10, no hazards -> next cycle alu_ctl=0110, alu_a=12, alu_b=10, ex_valid=1. Repeat with funct 100100/100101/101010/100111 -> 0000/0001/0111/1100.
- lw (ALUOp=00, alu_src=1, imm=-4, rs_data=100) -> alu_ctl=0010, alu_a=100, alu_b=0xFFFFFFFC, ex_dest=rt.
- rs=rt=5, exmem_rd=5 result 7, memwb_rd=5 result 9, both writing -> alu_a=alu_b=7. Drop exmem_reg_write -> 9. Repeat with rs=rt=0 -> no forwarding.
- stall=1 for 3 cycles while id_* change -> outputs hold the original instruction. flush=1 with stall=1 -> next cycle ex_valid=0, ex_reg_write=0.
- Illegal funct 000000 with ALUOp=10 -> ex_illegal=1, alu_ctl=0010, ex_reg_write=0. Assert reset mid-stream -> all cleared next edge.
